// File: rtl/irt_scoreboard.sv
// Instruction scoreboard: tracks up to BS in-flight instructions, records
// RAW/WAR/WAW dependencies between them at insert time, clears them as
// instructions complete, and reports which occupied slots may issue.
module irt_scoreboard #(
    parameter int REGNUM   = 32,
    parameter int BS       = 16,
    parameter int NSRC     = 2,
    parameter int ZERO_REG = 1,
    localparam int RA = $clog2(REGNUM),
    localparam int BI = $clog2(BS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [NSRC*RA-1:0]   in_rs,
    input  logic [NSRC-1:0]      in_rs_en,
    input  logic [RA-1:0]        in_rd,
    input  logic                 in_rd_en,
    output logic [BI-1:0]        alloc_index,
    input  logic                 cpl_valid,
    input  logic [BI-1:0]        cpl_index,
    output logic                 idt_valid,
    output logic [BS-1:0]        idt,
    output logic [BS-1:0]        slot_valid,
    output logic [BS-1:0]        issue_rdy,
    output logic [BI:0]          occupancy
);

    logic [BS-1:0]   slot_valid_q;
    logic [BS-1:0]   dep_q [BS];
    logic [RA-1:0]   src_q [BS][NSRC];
    logic [NSRC-1:0] src_en_q [BS];
    logic [RA-1:0]   dst_q [BS];
    logic [BS-1:0]   dst_en_q;
    logic [BI:0]     occ_q;
    logic            idt_valid_q;
    logic [BS-1:0]   idt_q;

    logic [NSRC-1:0] src_en_eff;
    logic            dst_en_eff;
    logic [BI-1:0]   alloc_idx;
    logic [BS-1:0]   alloc_mask;
    logic            accept;
    logic            cpl_ok;
    logic [BS-1:0]   cpl_mask;
    logic [BS-1:0]   dep_hit;
    logic [BS-1:0]   dep_new;

    // Operand qualification: register 0 behaves as "no operand" when ZERO_REG is set
    always_comb begin
        for (int k = 0; k < NSRC; k++) begin
            src_en_eff[k] = in_rs_en[k] &
                            ((ZERO_REG == 0) || (in_rs[k*RA +: RA] != '0));
        end
        dst_en_eff = in_rd_en & ((ZERO_REG == 0) || (in_rd != '0));
    end

    // Lowest free slot from the start-of-cycle occupancy; 0 when full
    always_comb begin
        alloc_idx = '0;
        for (int i = BS - 1; i >= 0; i--) begin
            if (!slot_valid_q[i]) alloc_idx = BI'(i);
        end
    end

    // Handshake and completion qualification
    always_comb begin
        in_ready   = ~&slot_valid_q;
        accept     = in_valid & in_ready;
        alloc_mask = BS'(1) << alloc_idx;
        cpl_ok     = cpl_valid & slot_valid_q[cpl_index];
        cpl_mask   = cpl_ok ? (BS'(1) << cpl_index) : '0;
    end

    // Hazard search against every stored instruction: RAW, WAR and WAW
    always_comb begin
        dep_hit = '0;
        for (int j = 0; j < BS; j++) begin
            for (int k = 0; k < NSRC; k++) begin
                if (src_en_eff[k] && dst_en_q[j] && (dst_q[j] == in_rs[k*RA +: RA]))
                    dep_hit[j] = 1'b1;
                if (dst_en_eff && src_en_q[j][k] && (src_q[j][k] == in_rd))
                    dep_hit[j] = 1'b1;
            end
            if (dst_en_eff && dst_en_q[j] && (dst_q[j] == in_rd))
                dep_hit[j] = 1'b1;
        end
        // A slot finishing this cycle can never hold up the newcomer
        dep_new = dep_hit & slot_valid_q & ~alloc_mask & ~cpl_mask;
    end

    // Slot occupancy, dependency matrix, counter and insert report
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            slot_valid_q <= '0;
            occ_q        <= '0;
            idt_valid_q  <= 1'b0;
            idt_q        <= '0;
            for (int i = 0; i < BS; i++) dep_q[i] <= '0;
        end else begin
            slot_valid_q <= (slot_valid_q & ~cpl_mask) | (accept ? alloc_mask : '0);
            for (int i = 0; i < BS; i++) begin
                if (accept && (BI'(i) == alloc_idx))
                    dep_q[i] <= dep_new;
                else if (cpl_ok && (BI'(i) == cpl_index))
                    dep_q[i] <= '0;
                else
                    dep_q[i] <= dep_q[i] & ~cpl_mask;
            end
            if (accept && !cpl_ok)
                occ_q <= occ_q + {{BI{1'b0}}, 1'b1};
            else if (!accept && cpl_ok)
                occ_q <= occ_q - {{BI{1'b0}}, 1'b1};
            idt_valid_q <= accept;
            if (accept) idt_q <= dep_new;
        end
    end

    // Source/destination tables: written on insert, invalidated on completion
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dst_en_q <= '0;
            for (int i = 0; i < BS; i++) begin
                src_en_q[i] <= '0;
                dst_q[i]    <= '0;
                for (int k = 0; k < NSRC; k++) src_q[i][k] <= '0;
            end
        end else begin
            if (cpl_ok) begin
                src_en_q[cpl_index] <= '0;
                dst_en_q[cpl_index] <= 1'b0;
            end
            if (accept) begin
                src_en_q[alloc_idx] <= src_en_eff;
                dst_en_q[alloc_idx] <= dst_en_eff;
                dst_q[alloc_idx]    <= in_rd;
                for (int k = 0; k < NSRC; k++)
                    src_q[alloc_idx][k] <= in_rs[k*RA +: RA];
            end
        end
    end

    // A slot may issue once it is occupied and nothing older blocks it
    always_comb begin
        for (int i = 0; i < BS; i++) issue_rdy[i] = slot_valid_q[i] & ~|dep_q[i];
    end

    assign alloc_index = alloc_idx;
    assign slot_valid  = slot_valid_q;
    assign occupancy   = occ_q;
    assign idt_valid   = idt_valid_q;
    assign idt         = idt_q;

endmodule

// File: tb/tb_irt_scoreboard.sv
// Bench for irt_scoreboard: directed scenarios plus a randomized run, all
// checked against an instruction-level reference model of the scoreboard.
module tb_irt_scoreboard;

    localparam int BS = 16;
    localparam int RA = 5;
    localparam int BI = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_valid_b = 1'b0;
    logic            cpl_valid_b = 1'b0;
    logic [2*RA-1:0] in_rs = '0;
    logic [1:0]      in_rs_en = '0;
    logic [RA-1:0]   in_rd = '0;
    logic            in_rd_en = 1'b0;
    logic            cpl_valid = 1'b0;
    logic [BI-1:0]   cpl_index = '0;

    logic            in_ready, idt_valid;
    logic [BI-1:0]   alloc_index;
    logic [BS-1:0]   idt, slot_valid, issue_rdy;
    logic [BI:0]     occupancy;

    logic            b_in_ready, b_idt_valid;
    logic [BI-1:0]   b_alloc_index;
    logic [BS-1:0]   b_idt, b_slot_valid, b_issue_rdy;
    logic [BI:0]     b_occupancy;

    int cmp = 0;
    int err = 0;

    irt_scoreboard #(.REGNUM(32), .BS(BS), .NSRC(2), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_rs(in_rs), .in_rs_en(in_rs_en), .in_rd(in_rd), .in_rd_en(in_rd_en),
        .alloc_index(alloc_index), .cpl_valid(cpl_valid), .cpl_index(cpl_index),
        .idt_valid(idt_valid), .idt(idt), .slot_valid(slot_valid),
        .issue_rdy(issue_rdy), .occupancy(occupancy)
    );

    irt_scoreboard #(.REGNUM(32), .BS(BS), .NSRC(2), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid_b), .in_ready(b_in_ready),
        .in_rs(in_rs), .in_rs_en(in_rs_en), .in_rd(in_rd), .in_rd_en(in_rd_en),
        .alloc_index(b_alloc_index), .cpl_valid(cpl_valid_b), .cpl_index(cpl_index),
        .idt_valid(b_idt_valid), .idt(b_idt), .slot_valid(b_slot_valid),
        .issue_rdy(b_issue_rdy), .occupancy(b_occupancy)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (instruction level) ----------------
    logic [BS-1:0] m_valid;
    logic [BS-1:0] m_dep [BS];
    int            m_rs  [BS][2];
    bit            m_rse [BS][2];
    int            m_rd  [BS];
    bit            m_rde [BS];
    bit            m_idt_valid;
    logic [BS-1:0] m_idt;
    bit            e_ready;
    int            e_alloc;
    logic          obs_ready;
    logic [BI-1:0] obs_alloc;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < BS; i++) if (m_valid[i]) n++;
        return n;
    endfunction

    function automatic logic [BS-1:0] m_issue();
        logic [BS-1:0] r = '0;
        for (int i = 0; i < BS; i++) r[i] = m_valid[i] && (m_dep[i] == '0);
        return r;
    endfunction

    task automatic model_reset();
        m_valid = '0; m_idt_valid = 0; m_idt = '0;
        for (int i = 0; i < BS; i++) begin
            m_dep[i] = '0; m_rd[i] = 0; m_rde[i] = 0;
            for (int k = 0; k < 2; k++) begin m_rs[i][k] = 0; m_rse[i][k] = 0; end
        end
    endtask

    task automatic model_pre();
        e_ready = (m_count() < BS);
        e_alloc = 0;
        for (int i = BS - 1; i >= 0; i--) if (!m_valid[i]) e_alloc = i;
    endtask

    task automatic model_post(input bit iv, input logic [2*RA-1:0] rs, input logic [1:0] rse,
                              input int rd, input bit rde, input bit cv, input int ci);
        bit acc, cok, d_en;
        int src[2];
        bit s_en[2];
        logic [BS-1:0] nd = '0;
        acc = iv && e_ready;
        cok = cv && m_valid[ci];
        for (int k = 0; k < 2; k++) begin
            src[k]  = int'(rs[k*RA +: RA]);
            s_en[k] = rse[k] && (src[k] != 0);
        end
        d_en = rde && (rd != 0);
        if (acc) begin
            for (int j = 0; j < BS; j++) begin
                if (m_valid[j] && !(cok && j == ci)) begin
                    for (int k = 0; k < 2; k++) begin
                        if (s_en[k] && m_rde[j] && m_rd[j] == src[k]) nd[j] = 1'b1;
                        if (d_en && m_rse[j][k] && m_rs[j][k] == rd) nd[j] = 1'b1;
                    end
                    if (d_en && m_rde[j] && m_rd[j] == rd) nd[j] = 1'b1;
                end
            end
        end
        if (cok) begin
            m_valid[ci] = 1'b0; m_rde[ci] = 0; m_rse[ci][0] = 0; m_rse[ci][1] = 0;
            m_dep[ci] = '0;
            for (int i = 0; i < BS; i++) m_dep[i][ci] = 1'b0;
        end
        if (acc) begin
            m_valid[e_alloc] = 1'b1;
            m_dep[e_alloc]   = nd;
            m_rd[e_alloc]    = rd;
            m_rde[e_alloc]   = d_en;
            for (int k = 0; k < 2; k++) begin
                m_rs[e_alloc][k] = src[k]; m_rse[e_alloc][k] = s_en[k];
            end
            m_idt = nd;
        end
        m_idt_valid = acc;
    endtask

    // One clock of stimulus; leaves time at posedge+1 with inputs idle
    task automatic drive_step(input bit iv, input logic [2*RA-1:0] rs, input logic [1:0] rse,
                              input int rd, input bit rde, input bit cv, input int ci);
        in_valid = iv; in_rs = rs; in_rs_en = rse; in_rd = RA'(rd); in_rd_en = rde;
        cpl_valid = cv; cpl_index = BI'(ci);
        model_pre();
        #1;
        obs_ready = in_ready;
        obs_alloc = alloc_index;
        model_post(iv, rs, rse, rd, rde, cv, ci);
        @(posedge clk); #1;
        in_valid = 1'b0; cpl_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        in_valid = 1'b0; cpl_valid = 1'b0; in_valid_b = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        #1;
        cmp++; if (slot_valid !== '0) begin err++; $display("FAIL reset_slot_valid: got %h want 0", slot_valid); end
        cmp++; if (occupancy !== '0) begin err++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
        cmp++; if (in_ready !== 1'b1) begin err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        cmp++; if (alloc_index !== '0) begin err++; $display("FAIL reset_alloc: got %0d want 0", alloc_index); end
        cmp++; if (idt_valid !== 1'b0 || idt !== '0) begin err++; $display("FAIL reset_idt: got %b/%h want 0/0", idt_valid, idt); end
        cmp++; if (issue_rdy !== '0) begin err++; $display("FAIL reset_issue: got %h want 0", issue_rdy); end
    endtask

    task automatic test_raw();
        do_reset();
        drive_step(1, {5'd2, 5'd1}, 2'b11, 3, 1, 0, 0);
        cmp++; if (obs_alloc !== 4'd0) begin err++; $display("FAIL raw_alloc0: got %0d want 0", obs_alloc); end
        cmp++; if (idt_valid !== 1'b1 || idt !== 16'h0000) begin err++; $display("FAIL raw_idt0: got %b/%h want 1/0000", idt_valid, idt); end
        cmp++; if (issue_rdy !== 16'h0001) begin err++; $display("FAIL raw_issue0: got %h want 0001", issue_rdy); end
        drive_step(1, {5'd4, 5'd3}, 2'b11, 5, 1, 0, 0);
        cmp++; if (obs_alloc !== 4'd1) begin err++; $display("FAIL raw_alloc1: got %0d want 1", obs_alloc); end
        cmp++; if (idt !== 16'h0001) begin err++; $display("FAIL raw_idt1: got %h want 0001", idt); end
        cmp++; if (issue_rdy !== 16'h0001) begin err++; $display("FAIL raw_issue1: got %h want 0001", issue_rdy); end
        drive_step(0, '0, 2'b00, 0, 0, 1, 0);
        cmp++; if (issue_rdy !== 16'h0002 || slot_valid !== 16'h0002) begin err++; $display("FAIL raw_cpl: got %h/%h want 0002/0002", issue_rdy, slot_valid); end
        cmp++; if (idt_valid !== 1'b0 || idt !== 16'h0001) begin err++; $display("FAIL raw_idt_hold: got %b/%h want 0/0001", idt_valid, idt); end
        cmp++; if (occupancy !== 5'd1) begin err++; $display("FAIL raw_occ: got %0d want 1", occupancy); end
    endtask

    task automatic test_war_waw();
        do_reset();
        drive_step(1, {5'd8, 5'd7}, 2'b11, 9, 1, 0, 0);
        drive_step(1, '0, 2'b00, 7, 1, 0, 0);
        cmp++; if (idt !== 16'h0001) begin err++; $display("FAIL war_idt: got %h want 0001", idt); end
        drive_step(1, '0, 2'b00, 9, 1, 0, 0);
        cmp++; if (idt !== 16'h0001) begin err++; $display("FAIL waw_idt: got %h want 0001", idt); end
        cmp++; if (issue_rdy !== 16'h0001 || slot_valid !== 16'h0007) begin err++; $display("FAIL waw_issue: got %h/%h want 0001/0007", issue_rdy, slot_valid); end
    endtask

    task automatic test_zero_reg();
        do_reset();
        in_valid_b = 1'b1;
        drive_step(1, '0, 2'b00, 0, 1, 0, 0);
        drive_step(1, {5'd0, 5'd0}, 2'b11, 0, 1, 0, 0);
        in_valid_b = 1'b0;
        cmp++; if (idt_valid !== 1'b1 || idt !== 16'h0000) begin err++; $display("FAIL zero_idt_z1: got %b/%h want 1/0000", idt_valid, idt); end
        cmp++; if (b_idt_valid !== 1'b1 || b_idt !== 16'h0001) begin err++; $display("FAIL zero_idt_z0: got %b/%h want 1/0001", b_idt_valid, b_idt); end
        cmp++; if (issue_rdy !== 16'h0003 || b_issue_rdy !== 16'h0001) begin err++; $display("FAIL zero_issue: got %h/%h want 0003/0001", issue_rdy, b_issue_rdy); end
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < BS; i++) begin
            drive_step(1, {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                       2'($urandom_range(0, 3)), $urandom_range(0, 7), 1'($urandom_range(0, 1)), 0, 0);
            cmp++; if (obs_alloc !== BI'(i)) begin err++; $display("FAIL full_alloc%0d: got %0d want %0d", i, obs_alloc, i); end
            cmp++; if (idt !== m_idt) begin err++; $display("FAIL full_idt%0d: got %h want %h", i, idt, m_idt); end
        end
        cmp++; if (occupancy !== 5'd16 || in_ready !== 1'b0) begin err++; $display("FAIL full_state: got occ %0d rdy %b want 16/0", occupancy, in_ready); end
        cmp++; if (alloc_index !== 4'd0) begin err++; $display("FAIL full_alloc_stable: got %0d want 0", alloc_index); end
        drive_step(1, {5'd1, 5'd2}, 2'b11, 3, 1, 0, 0);
        cmp++; if (idt_valid !== 1'b0 || occupancy !== 5'd16 || slot_valid !== 16'hffff) begin err++; $display("FAIL full_reject: got %b/%0d/%h want 0/16/ffff", idt_valid, occupancy, slot_valid); end
        drive_step(1, {5'd1, 5'd2}, 2'b11, 3, 1, 1, 5);
        cmp++; if (occupancy !== 5'd15 || slot_valid !== 16'hffdf || idt_valid !== 1'b0) begin err++; $display("FAIL full_cpl5: got %0d/%h/%b want 15/ffdf/0", occupancy, slot_valid, idt_valid); end
        cmp++; if (in_ready !== 1'b1 || alloc_index !== 4'd5) begin err++; $display("FAIL full_free5: got %b/%0d want 1/5", in_ready, alloc_index); end
        drive_step(1, '0, 2'b00, 6, 1, 0, 0);
        cmp++; if (obs_alloc !== 4'd5 || occupancy !== 5'd16) begin err++; $display("FAIL full_realloc: got %0d/%0d want 5/16", obs_alloc, occupancy); end
        cmp++; if (idt !== m_idt || issue_rdy !== m_issue()) begin err++; $display("FAIL full_model: got %h/%h want %h/%h", idt, issue_rdy, m_idt, m_issue()); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        drive_step(1, '0, 2'b00, 1, 1, 0, 0);
        drive_step(1, '0, 2'b00, 2, 1, 0, 0);
        drive_step(1, '0, 2'b00, 10, 1, 0, 0);
        drive_step(1, {5'd0, 5'd10}, 2'b01, 11, 1, 1, 2);
        cmp++; if (obs_alloc !== 4'd3) begin err++; $display("FAIL same_alloc: got %0d want 3", obs_alloc); end
        cmp++; if (idt !== 16'h0000 || idt_valid !== 1'b1) begin err++; $display("FAIL same_idt: got %h/%b want 0000/1", idt, idt_valid); end
        cmp++; if (slot_valid !== 16'h000b || occupancy !== 5'd3) begin err++; $display("FAIL same_slots: got %h/%0d want 000b/3", slot_valid, occupancy); end
        drive_step(0, '0, 2'b00, 0, 0, 1, 9);
        cmp++; if (slot_valid !== 16'h000b || occupancy !== 5'd3 || issue_rdy !== 16'h000b) begin err++; $display("FAIL empty_cpl: got %h/%0d/%h want 000b/3/000b", slot_valid, occupancy, issue_rdy); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive_step($urandom_range(0, 3) != 0,
                       {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))},
                       2'($urandom_range(0, 3)), $urandom_range(0, 7), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 1)), $urandom_range(0, BS - 1));
            cmp++; if (obs_ready !== e_ready) begin err++; $display("FAIL rnd_ready@%0d: got %b want %b", n, obs_ready, e_ready); end
            if (e_ready) begin
                cmp++; if (obs_alloc !== BI'(e_alloc)) begin err++; $display("FAIL rnd_alloc@%0d: got %0d want %0d", n, obs_alloc, e_alloc); end
            end
            cmp++; if (slot_valid !== m_valid) begin err++; $display("FAIL rnd_slots@%0d: got %h want %h", n, slot_valid, m_valid); end
            cmp++; if (issue_rdy !== m_issue()) begin err++; $display("FAIL rnd_issue@%0d: got %h want %h", n, issue_rdy, m_issue()); end
            cmp++; if (occupancy !== 5'(m_count())) begin err++; $display("FAIL rnd_occ@%0d: got %0d want %0d", n, occupancy, m_count()); end
            cmp++; if (idt_valid !== m_idt_valid || idt !== m_idt) begin err++; $display("FAIL rnd_idt@%0d: got %b/%h want %b/%h", n, idt_valid, idt, m_idt_valid, m_idt); end
        end
    endtask

    task automatic test_async_reset();
        drive_step(1, {5'd1, 5'd2}, 2'b11, 4, 1, 0, 0);
        #2 rst = 1'b0;
        #1;
        cmp++; if (slot_valid !== '0 || occupancy !== '0 || issue_rdy !== '0) begin err++; $display("FAIL async_state: got %h/%0d/%h want 0/0/0", slot_valid, occupancy, issue_rdy); end
        cmp++; if (idt_valid !== 1'b0 || idt !== '0) begin err++; $display("FAIL async_idt: got %b/%h want 0/0", idt_valid, idt); end
        cmp++; if (in_ready !== 1'b1 || alloc_index !== '0) begin err++; $display("FAIL async_ready: got %b/%0d want 1/0", in_ready, alloc_index); end
        model_reset();
        @(negedge clk) rst = 1'b1;
        drive_step(1, '0, 2'b00, 6, 1, 0, 0);
        cmp++; if (obs_alloc !== 4'd0 || slot_valid !== 16'h0001) begin err++; $display("FAIL async_first: got %0d/%h want 0/0001", obs_alloc, slot_valid); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_raw();
        test_war_waw();
        test_zero_reg();
        test_full();
        test_same_cycle();
        test_random();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
        $finish;
    end

endmodule
